ps2_digit_tx: RTL

//  Keyboard-side PS/2 transmitter for decimal digits. On a digit request it emits the

---
 rtl/ps2_digit_tx_pkg.sv | 48 ++++
 rtl/ps2_frame_tx.sv | 94 +++++++++
 rtl/ps2_digit_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/ps2_digit_tx_pkg.sv
// Shared PS/2 definitions: set-2 make codes for the decimal digits, break prefix,
// and the state encodings used by the keystroke sequencer and byte serializer.
package ps2_digit_tx_pkg;

    localparam logic [7:0] KEY_0 = 8'h45;
    localparam logic [7:0] KEY_1 = 8'h16;
    localparam logic [7:0] KEY_2 = 8'h1E;
    localparam logic [7:0] KEY_3 = 8'h26;
    localparam logic [7:0] KEY_4 = 8'h25;
    localparam logic [7:0] KEY_5 = 8'h2E;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h3D;
    localparam logic [7:0] KEY_8 = 8'h3E;
    localparam logic [7:0] KEY_9 = 8'h46;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_BIT_HI,
        FR_BIT_LO
    } frame_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_BYTE,
        SEQ_GAP
    } seq_state_t;

    function automatic logic [7:0] key_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = KEY_0;
            4'd1:    code = KEY_1;
            4'd2:    code = KEY_2;
            4'd3:    code = KEY_3;
            4'd4:    code = KEY_4;
            4'd5:    code = KEY_5;
            4'd6:    code = KEY_6;
            4'd7:    code = KEY_7;
            4'd8:    code = KEY_8;
            4'd9:    code = KEY_9;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Single-byte PS/2 serializer: start, 8 data bits LSB first, odd parity, stop.
// Each bit is CLK_DIV cycles with ps2_clk high followed by CLK_DIV cycles low.
module ps2_frame_tx
    import ps2_digit_tx_pkg::*;
#(
    parameter int CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       frame_done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'd10;

    frame_state_t     state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [3:0]       bit_idx, bit_idx_nxt;
    logic [10:0]      shreg;
    logic             load, shift;

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        bit_idx_nxt = bit_idx;
        load        = 1'b0;
        shift       = 1'b0;
        frame_done  = 1'b0;
        case (state)
            FR_IDLE: begin
                if (start) begin
                    state_nxt   = FR_BIT_HI;
                    div_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    load        = 1'b1;
                end
            end
            FR_BIT_HI: begin
                if (div_cnt == DIV_LAST) begin
                    state_nxt   = FR_BIT_LO;
                    div_cnt_nxt = '0;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            FR_BIT_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_nxt  = FR_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        state_nxt   = FR_BIT_HI;
                        bit_idx_nxt = bit_idx + 1'b1;
                        shift       = 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FR_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Frame bits are consumed from bit 0; the line only moves at the start of BIT_HI.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= {1'b1, ~^tx_byte, tx_byte, 1'b0};
        end else if (shift) begin
            shreg <= {1'b1, shreg[10:1]};
        end
    end

    assign ps2_clk  = (state != FR_BIT_LO);
    assign ps2_data = (state == FR_IDLE) ? 1'b1 : shreg[0];

endmodule

// File: rtl/ps2_digit_tx.sv
// PS/2 keystroke transmitter for a decimal digit: sends MAKE, F0, MAKE with an idle
// gap after every byte, and reports completion, bad digits and overlapping requests.
module ps2_digit_tx
    import ps2_digit_tx_pkg::*;
#(
    parameter int CLK_DIV  = 2500,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic       control,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       drop
);

    localparam int               GAP_CYC  = 2 * GAP_BITS * CLK_DIV;
    localparam int               GAP_W    = $clog2(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    seq_state_t       seq, seq_nxt;
    logic [1:0]       byte_idx, byte_idx_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [7:0]       make_q;
    logic [7:0]       tx_byte;
    logic             accept, frame_start, frame_done, done_nxt;

    assign busy   = (seq != SEQ_IDLE);
    assign accept = control && !busy && (num <= 4'd9);

    always_comb begin
        seq_nxt      = seq;
        byte_idx_nxt = byte_idx;
        gap_cnt_nxt  = gap_cnt;
        frame_start  = 1'b0;
        tx_byte      = make_q;
        done_nxt     = 1'b0;
        case (seq)
            SEQ_IDLE: begin
                if (accept) begin
                    seq_nxt      = SEQ_BYTE;
                    byte_idx_nxt = '0;
                    frame_start  = 1'b1;
                    tx_byte      = key_code(num);
                end
            end
            SEQ_BYTE: begin
                if (frame_done) begin
                    seq_nxt     = SEQ_GAP;
                    gap_cnt_nxt = '0;
                end
            end
            SEQ_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (byte_idx == 2'd2) begin
                        seq_nxt  = SEQ_IDLE;
                        done_nxt = 1'b1;
                    end else begin
                        // The next byte starts in this cycle so the gap stays exactly GAP_CYC long.
                        seq_nxt      = SEQ_BYTE;
                        byte_idx_nxt = byte_idx + 2'd1;
                        frame_start  = 1'b1;
                        tx_byte      = (byte_idx == 2'd0) ? BREAK_PREFIX : make_q;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: seq_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq      <= SEQ_IDLE;
            byte_idx <= '0;
            gap_cnt  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            seq      <= seq_nxt;
            byte_idx <= byte_idx_nxt;
            gap_cnt  <= gap_cnt_nxt;
            done     <= done_nxt;
            err      <= control && !busy && (num > 4'd9);
            drop     <= control && busy;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            make_q <= key_code(num);
        end
    end

    ps2_frame_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_frame_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (frame_start),
        .tx_byte   (tx_byte),
        .frame_done(frame_done),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data)
    );

endmodule
